// File: rtl/spin_node.sv
// Clocked spin node: flips its spin when a strict majority of enabled couplings
// disagree, with post-flip hold time, saturating flip counter and stability flag.
module spin_node #(
  parameter int N_IN          = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int FLIP_W        = 16,
  parameter int STABLE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              init_spin,
  input  logic [N_IN-1:0]   couple_in,
  input  logic [N_IN-1:0]   mask,
  output logic              spin,
  output logic [FLIP_W-1:0] flip_count,
  output logic              stable
);

  localparam int CNT_W  = $clog2(N_IN + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t            state, state_n;
  logic              spin_n;
  logic [FLIP_W-1:0] flip_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [STAB_W-1:0] stable_cnt, stable_n;
  logic [CNT_W-1:0]  disagree, active;
  logic              flip_req;

  // Vote; doubling disagree at CNT_W+1 bits keeps ties and empty masks from flipping.
  always_comb begin
    disagree = '0;
    active   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (mask[i]) begin
        active = active + CNT_W'(1);
        if (couple_in[i] != spin) disagree = disagree + CNT_W'(1);
      end
    end
    flip_req = {disagree, 1'b0} > {1'b0, active};
  end

  always_comb begin
    state_n  = state;
    spin_n   = spin;
    flip_n   = flip_count;
    hold_n   = hold_cnt;
    stable_n = stable_cnt;
    if (load) begin
      spin_n   = init_spin;
      flip_n   = '0;
      stable_n = '0;
      if (!en) begin
        state_n = IDLE;
      end else if (HOLD_CYCLES > 0) begin
        state_n = HOLD;
        hold_n  = HOLD_INIT;
      end else begin
        state_n = RUN;
      end
    end else begin
      case (state)
        IDLE: if (en) state_n = RUN;
        RUN: begin
          if (!en) begin
            state_n = IDLE;
          end else if (flip_req) begin
            spin_n   = ~spin;
            stable_n = '0;
            if (flip_count != '1) flip_n = flip_count + FLIP_W'(1);
            if (HOLD_CYCLES > 0) begin
              state_n = HOLD;
              hold_n  = HOLD_INIT;
            end
          end else if (stable_cnt != STAB_MAX) begin
            stable_n = stable_cnt + STAB_W'(1);
          end
        end
        HOLD: begin
          if (!en)                state_n = IDLE;
          else if (hold_cnt == 0) state_n = RUN;
          else                    hold_n  = hold_cnt - HOLD_W'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      spin       <= 1'b0;
      flip_count <= '0;
      hold_cnt   <= '0;
      stable_cnt <= '0;
    end else begin
      state      <= state_n;
      spin       <= spin_n;
      flip_count <= flip_n;
      hold_cnt   <= hold_n;
      stable_cnt <= stable_n;
    end
  end

  assign stable = (stable_cnt == STAB_MAX);

endmodule
